// File: rtl/bubsys_video_pkg.sv
// Shared video-path definitions: palette width, layer codes and the tile attribute layout.
package bubsys_video_pkg;

  localparam int PAL_W = 7;

  localparam logic [1:0] LYR_BACK = 2'd0;
  localparam logic [1:0] LYR_B    = 2'd1;
  localparam logic [1:0] LYR_A    = 2'd2;
  localparam logic [1:0] LYR_OBJ  = 2'd3;

  typedef struct packed {
    logic             prio;
    logic [PAL_W-1:0] pal;
  } attr_t;

endpackage

// File: rtl/bubsys_attr_aligner.sv
// Delays a latched tile attribute by DLY pixel-clock enables so it lines up with
// the pixels that leave the tilemap shifter.
module bubsys_attr_aligner #(
  parameter int DLY = 0,
  parameter int W   = $bits(bubsys_video_pkg::attr_t)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cen,
  input  logic         i_ld,
  input  logic [W-1:0] i_attr,
  output logic [W-1:0] o_cur
);

  logic [W-1:0] pend_q, pend_d;
  logic [W-1:0] cur_q, cur_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         act_q, act_d;

  // A fresh load always wins over an in-flight transfer, so the older attribute is dropped.
  always_comb begin
    pend_d = pend_q;
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    if (i_ld) begin
      pend_d = i_attr;
      if (DLY == 0) begin
        cur_d = i_attr;
      end else begin
        cnt_d = 4'(DLY);
        act_d = 1'b1;
      end
    end else if (act_q) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        cur_d = pend_q;
        act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
      cur_q  <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
    end else if (i_cen) begin
      pend_q <= pend_d;
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
    end
  end

  assign o_cur = cur_q;

endmodule

// File: rtl/bubsys_layer_mixer.sv
// Resolves tilemap A, tilemap B and sprite priority per pixel and registers the
// resulting colour-RAM address for the palette stage.
module bubsys_layer_mixer #(
  parameter int A_ATTR_DLY = 4,
  parameter int B_ATTR_DLY = 0,
  parameter int PAL_W      = bubsys_video_pkg::PAL_W
) (
  input  logic               i_EMU_MCLK,
  input  logic               i_EMU_RST_n,
  input  logic               i_EMU_CLK6MPCEN_n,
  input  logic [3:0]         i_A_PIXEL,
  input  logic               i_A_TRN_n,
  input  logic [3:0]         i_B_PIXEL,
  input  logic               i_B_TRN_n,
  input  logic [3:0]         i_OBJ_PIXEL,
  input  logic [PAL_W-1:0]   i_OBJ_PAL,
  input  logic               i_A_ATTR_LD,
  input  logic [PAL_W:0]     i_A_ATTR,
  input  logic               i_B_ATTR_LD,
  input  logic [PAL_W:0]     i_B_ATTR,
  input  logic               i_BLANK_n,
  output logic [PAL_W+3:0]   o_CRAM_ADDR,
  output logic [1:0]         o_LAYER
);

  import bubsys_video_pkg::*;

  logic             cen;
  logic [PAL_W:0]   a_cur, b_cur;
  logic             a_prio, b_prio;
  logic             aop, bop, objop;
  logic [PAL_W+3:0] addr_q, addr_d;
  logic [1:0]       layer_q, layer_d;

  assign cen = ~i_EMU_CLK6MPCEN_n;

  bubsys_attr_aligner #(.DLY(A_ATTR_DLY), .W(PAL_W+1)) u_a_align (
    .i_clk   (i_EMU_MCLK),
    .i_rst_n (i_EMU_RST_n),
    .i_cen   (cen),
    .i_ld    (i_A_ATTR_LD),
    .i_attr  (i_A_ATTR),
    .o_cur   (a_cur)
  );

  bubsys_attr_aligner #(.DLY(B_ATTR_DLY), .W(PAL_W+1)) u_b_align (
    .i_clk   (i_EMU_MCLK),
    .i_rst_n (i_EMU_RST_n),
    .i_cen   (cen),
    .i_ld    (i_B_ATTR_LD),
    .i_attr  (i_B_ATTR),
    .o_cur   (b_cur)
  );

  assign a_prio = a_cur[PAL_W];
  assign b_prio = b_cur[PAL_W];
  assign aop    = i_A_TRN_n;
  assign bop    = i_B_TRN_n;
  assign objop  = (i_OBJ_PIXEL != 4'd0);

  // A prioritised B may sit above sprites but never above an opaque A pixel.
  always_comb begin
    addr_d  = '0;
    layer_d = LYR_BACK;
    if (!i_BLANK_n) begin
      addr_d  = '0;
      layer_d = LYR_BACK;
    end else if (aop && a_prio) begin
      addr_d  = {a_cur[PAL_W-1:0], i_A_PIXEL};
      layer_d = LYR_A;
    end else if (bop && b_prio && !aop) begin
      addr_d  = {b_cur[PAL_W-1:0], i_B_PIXEL};
      layer_d = LYR_B;
    end else if (objop) begin
      addr_d  = {i_OBJ_PAL, i_OBJ_PIXEL};
      layer_d = LYR_OBJ;
    end else if (aop) begin
      addr_d  = {a_cur[PAL_W-1:0], i_A_PIXEL};
      layer_d = LYR_A;
    end else if (bop) begin
      addr_d  = {b_cur[PAL_W-1:0], i_B_PIXEL};
      layer_d = LYR_B;
    end
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      addr_q  <= '0;
      layer_q <= LYR_BACK;
    end else if (cen) begin
      addr_q  <= addr_d;
      layer_q <= layer_d;
    end
  end

  assign o_CRAM_ADDR = addr_q;
  assign o_LAYER     = layer_q;

endmodule

// File: tb/tb_bubsys_layer_mixer.sv
// Directed bench for bubsys_layer_mixer: attribute alignment, reset abort,
// priority resolution, blanking and clock-enable hold.
module tb_bubsys_layer_mixer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen_n = 1'b0;
  logic [3:0]  a_pix = 4'd0, b_pix = 4'd0, obj_pix = 4'd0;
  logic        a_trn_n = 1'b0, b_trn_n = 1'b0;
  logic [6:0]  obj_pal = 7'd0;
  logic        a_ld = 1'b0, b_ld = 1'b0;
  logic [7:0]  a_attr = 8'd0, b_attr = 8'd0;
  logic        blank_n = 1'b1;
  logic [10:0] addr;
  logic [1:0]  layer;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bubsys_layer_mixer #(.A_ATTR_DLY(4), .B_ATTR_DLY(0), .PAL_W(7)) u_dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_RST_n       (rst_n),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .i_A_PIXEL         (a_pix),
    .i_A_TRN_n         (a_trn_n),
    .i_B_PIXEL         (b_pix),
    .i_B_TRN_n         (b_trn_n),
    .i_OBJ_PIXEL       (obj_pix),
    .i_OBJ_PAL         (obj_pal),
    .i_A_ATTR_LD       (a_ld),
    .i_A_ATTR          (a_attr),
    .i_B_ATTR_LD       (b_ld),
    .i_B_ATTR          (b_attr),
    .i_BLANK_n         (blank_n),
    .o_CRAM_ADDR       (addr),
    .o_LAYER           (layer)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One MCLK edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic [3:0] ap, input logic ao, input logic [3:0] bp,
                        input logic bo, input logic [3:0] op, input logic [6:0] opal);
    a_pix = ap; a_trn_n = ao; b_pix = bp; b_trn_n = bo; obj_pix = op; obj_pal = opal;
  endtask

  task automatic load_a(input logic [7:0] v);
    a_attr = v; a_ld = 1'b1;
    tick();
    a_ld = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] v);
    b_attr = v; b_ld = 1'b1;
    tick();
    b_ld = 1'b0;
  endtask

  logic [10:0] held_addr;
  logic [1:0]  held_layer;

  initial begin
    // Reset state
    #12;
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_layer", 32'(layer), 32'h0);
    rst_n = 1'b1;
    tick();

    // Reset aborts a pending A transfer
    set_px(4'h5, 1'b1, 4'h0, 1'b0, 4'h0, 7'h00);
    load_a(8'h85);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("midrst_addr", 32'(addr), 32'h0);
    check("midrst_layer", 32'(layer), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("post_rst_addr%0d", i), 32'(addr), 32'h005);
    end
    check("post_rst_layer", 32'(layer), 32'h2);

    // A alignment: load at edge 0, current at edge 4, visible at edge 5
    load_a(8'h85);
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("a_align_e%0d", e), 32'(addr), 32'h005);
    end
    tick();
    check("a_align_e5", 32'(addr), 32'h055);
    check("a_align_layer", 32'(layer), 32'h2);

    // B alignment with zero delay
    set_px(4'h0, 1'b0, 4'h9, 1'b1, 4'h0, 7'h00);
    load_b(8'h12);
    check("b_align_e0", 32'(addr), 32'h009);
    tick();
    check("b_align_e1", 32'(addr), 32'h129);
    check("b_align_layer", 32'(layer), 32'h1);

    // Reload restarts the counter; 0x11 never becomes current
    set_px(4'h5, 1'b1, 4'h0, 1'b0, 4'h0, 7'h00);
    load_a(8'h11);
    tick();
    a_attr = 8'h22; a_ld = 1'b1;
    tick();
    a_ld = 1'b0;
    for (int e = 3; e <= 6; e++) begin
      tick();
      check($sformatf("reload_e%0d", e), 32'(addr), 32'h055);
    end
    tick();
    check("reload_e7", 32'(addr), 32'h225);

    // Priority: A prio 0 loses to OBJ
    load_a(8'h01);
    load_b(8'h82);
    for (int i = 0; i < 5; i++) tick();
    set_px(4'h3, 1'b1, 4'h0, 1'b0, 4'h7, 7'h40);
    tick();
    check("obj_over_a_addr", 32'(addr), 32'h407);
    check("obj_over_a_layer", 32'(layer), 32'h3);
    // Opaque A (no prio) still beats prioritised B when OBJ is clear
    set_px(4'h3, 1'b1, 4'h9, 1'b1, 4'h0, 7'h40);
    tick();
    check("a_over_bprio_addr", 32'(addr), 32'h013);
    check("a_over_bprio_layer", 32'(layer), 32'h2);

    // A prio 1 beats OBJ
    load_a(8'h81);
    for (int i = 0; i < 5; i++) tick();
    set_px(4'h3, 1'b1, 4'h0, 1'b0, 4'h7, 7'h40);
    tick();
    check("a_prio_addr", 32'(addr), 32'h013);
    check("a_prio_layer", 32'(layer), 32'h2);

    // Prioritised B beats OBJ when A transparent
    set_px(4'h3, 1'b0, 4'h9, 1'b1, 4'h7, 7'h40);
    tick();
    check("b_prio_addr", 32'(addr), 32'h029);
    check("b_prio_layer", 32'(layer), 32'h1);

    // Backdrop
    set_px(4'h3, 1'b0, 4'h9, 1'b0, 4'h0, 7'h40);
    tick();
    check("backdrop_addr", 32'(addr), 32'h000);
    check("backdrop_layer", 32'(layer), 32'h0);

    // Blanking with everything opaque
    set_px(4'h3, 1'b1, 4'h9, 1'b1, 4'h7, 7'h40);
    blank_n = 1'b0;
    tick();
    check("blank_addr", 32'(addr), 32'h000);
    check("blank_layer", 32'(layer), 32'h0);
    blank_n = 1'b1;

    // CEN hold: A counter paused mid-count, outputs frozen
    set_px(4'h5, 1'b1, 4'h0, 1'b0, 4'h0, 7'h00);
    load_a(8'h33);
    tick();
    held_addr = addr;
    held_layer = layer;
    check("pre_hold_addr", 32'(held_addr), 32'h015);
    cen_n = 1'b1;
    set_px(4'h0, 1'b0, 4'h9, 1'b1, 4'h7, 7'h40);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_addr%0d", i), 32'(addr), 32'(held_addr));
      check($sformatf("hold_layer%0d", i), 32'(layer), 32'(held_layer));
    end
    set_px(4'h5, 1'b1, 4'h0, 1'b0, 4'h0, 7'h00);
    cen_n = 1'b0;
    for (int e = 2; e <= 4; e++) begin
      tick();
      check($sformatf("resume_e%0d", e), 32'(addr), 32'h015);
    end
    tick();
    check("resume_e5", 32'(addr), 32'h335);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
